alpha_fwd: RTL and testbench
============================

ALPHA_FWD -- requirements
Module: alpha_fwd

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-002 valid_blklen  in  1  block-length strobe; blklen  in  16  information bits per block, unsigned.
REQ-003 valid_in  in  1  symbol strobe; sys, parity, apriori  in  16 each  signed LLRs for one trellis step.
REQ-004 valid_blklen_out  out  1; blklen_out  out  16  accepted block length.
REQ-005 valid_branch, valid_alpha  out  1 each  step strobes, always identical.
REQ-006 init_branch1, init_branch2  out  16 each  signed branch metrics g1 and g2.
REQ-007 alpha_0 .. alpha_7  out  16 each  signed normalized forward metrics.
REQ-008 done  out  1  end-of-block pulse; err  out  1  rejected-length pulse; fsm_state  out  2  IDLE=0, RUN=1, DONE=2.

Function
REQ-009 FSM states SHALL be IDLE, RUN and DONE.
REQ-010 IDLE: on valid_blklen with 40 <= blklen <= 6144, SHALL latch blklen and go to RUN; valid_blklen_out SHALL pulse 1 cycle later, with blklen_out held until the next accepted length.
REQ-011 IDLE: on valid_blklen with blklen outside 40..6144, SHALL pulse err for 1 cycle and stay in IDLE.
REQ-012 RUN: SHALL accept exactly blklen+4 valid_in symbols, counted by a 16-bit step counter; on the last accepted symbol SHALL go to DONE.
REQ-013 DONE: SHALL last 1 cycle, assert done in that cycle, then return to IDLE.
REQ-014 valid_in outside RUN SHALL be ignored; valid_blklen outside IDLE SHALL be ignored.
REQ-015 Branch metrics SHALL be computed at 18-bit signed width, arithmetic-shifted right by 1, then saturated to [-32768, 32767]: g1 = (sys+apriori+parity)>>>1; g2 = (sys+apriori-parity)>>>1.
REQ-016 Latency: the symbol accepted at cycle t SHALL appear on init_branch1/2 with valid_branch=valid_alpha=1 at cycle t+1; throughput is 1 step per cycle, and gaps in valid_in are allowed.
REQ-017 Alphas output with step k SHALL be alpha_k, the state metrics before step k is applied; step 0 SHALL output alpha_0=0 and alpha_1..7=-128.
REQ-018 Internal alpha registers SHALL be 19-bit signed; in the cycle step k is output, they SHALL update as:
- a0'=max(a0+g1, a1-g1); a4'=max(a0-g1, a1+g1)
- a1'=max(a2-g2, a3+g2); a5'=max(a2+g2, a3-g2)
- a2'=max(a4+g2, a5-g2); a6'=max(a4-g2, a5+g2)
- a3'=max(a6-g1, a7+g1); a7'=max(a6+g1, a7-g1)
REQ-019 Normalization: after each update, a0' SHALL be subtracted from all eight metrics, so a0 is always 0.
REQ-020 Alpha outputs SHALL be the 19-bit values saturated to 16-bit signed.
REQ-021 On entering RUN, alpha registers SHALL reinitialize to 0, -128 x7.
REQ-022 Outputs SHALL hold their last values when valid is low.
REQ-023 Reaching the blklen+4 count SHALL take priority: any further valid_in in the same block SHALL be dropped.

Reset
REQ-024 rst low SHALL immediately clear all outputs and the step counter to 0, set FSM to IDLE and set alpha registers to 0, -128 x7, including mid-block; a block interrupted by reset SHALL be abandoned with no done pulse.
REQ-025 After rst is released, the first cycle SHALL accept valid_blklen.

Verification
REQ-026 blklen=40, 44 all-zero symbols -> 44 valid pulses, all g=0; step0 alphas {0,-128,-128,-128,-128,-128,-128,-128}; step1 {0,-128,-128,-128,0,-128,-128,-128}; done 1 cycle after the last valid.
REQ-027 First symbol sys=10, apriori=0, parity=4 -> g1=7, g2=3; step1 alphas a0..a7 = {0,-132,-132,-128,-14,-132,-132,-128}.
REQ-028 sys=apriori=parity=32767 -> g1=32767 (saturated), g2=16383; sys=apriori=parity=-32768 -> g1=-32768.
REQ-029 blklen=39, then blklen=6145 -> err pulses, fsm_state stays 0, no valid_blklen_out; blklen=6144 -> accepted, exactly 6148 valid steps.
REQ-030 rst low after 10 steps of a 40-bit block -> all outputs 0, fsm_state 0; a new block of blklen=40 restarts with step0 init alphas and emits 44 steps.
REQ-031 Random valid_in gaps plus extra valid_in after the final step -> output count is exactly blklen+4, and alphas match a reference model step for step.

Source files
------------

// File: rtl/alpha_fwd.sv
// alpha_fwd: forward (alpha) state-metric recursion for an 8-state trellis.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   valid_blklen, blklen     block-length strobe and length (40..6144 accepted)
//   valid_in, sys, parity,   per-step strobe and signed 16-bit LLRs
//   apriori
//   valid_blklen_out,        pulse one cycle after a length is accepted;
//   blklen_out               accepted length, held until the next acceptance
//   valid_branch,            step strobes (identical)
//   valid_alpha
//   init_branch1/2           saturated branch metrics g1/g2 of the step
//   alpha_0..alpha_7         saturated, normalized metrics before the step
//   done, err                end-of-block pulse, rejected-length pulse
//   fsm_state                IDLE=0, RUN=1, DONE=2
module alpha_fwd (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_blklen,
    input  logic [15:0]        blklen,
    input  logic               valid_in,
    input  logic signed [15:0] sys,
    input  logic signed [15:0] parity,
    input  logic signed [15:0] apriori,
    output logic               valid_blklen_out,
    output logic [15:0]        blklen_out,
    output logic               valid_branch,
    output logic               valid_alpha,
    output logic signed [15:0] init_branch1,
    output logic signed [15:0] init_branch2,
    output logic signed [15:0] alpha_0,
    output logic signed [15:0] alpha_1,
    output logic signed [15:0] alpha_2,
    output logic signed [15:0] alpha_3,
    output logic signed [15:0] alpha_4,
    output logic signed [15:0] alpha_5,
    output logic signed [15:0] alpha_6,
    output logic signed [15:0] alpha_7,
    output logic               done,
    output logic               err,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic signed [18:0] A_INIT [8] = '{19'sd0, -19'sd128, -19'sd128, -19'sd128,
                                                  -19'sd128, -19'sd128, -19'sd128, -19'sd128};

    state_t                    r_state;
    logic [15:0]               r_blklen;
    logic [15:0]               r_cnt;
    logic                      r_vbo;
    logic                      r_valid;
    logic                      r_done;
    logic                      r_err;
    logic signed [15:0]        r_g1;
    logic signed [15:0]        r_g2;
    logic signed [18:0]        r_a    [8];
    logic signed [15:0]        r_aout [8];

    logic signed [17:0]        w_s1, w_s2, w_h1, w_h2;
    logic signed [15:0]        w_g1, w_g2;
    logic signed [18:0]        w_g1x, w_g2x;
    logic signed [18:0]        w_n    [8];
    logic signed [18:0]        w_nn   [8];

    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            return 16'sh7FFF;
        else if (v < -19'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic signed [18:0] amax(input logic signed [18:0] x,
                                                input logic signed [18:0] y);
        return (x > y) ? x : y;
    endfunction

    // Branch metrics at 18 bits: the three-way sum cannot overflow there.
    always_comb begin
        w_s1  = {{2{sys[15]}}, sys} + {{2{apriori[15]}}, apriori} + {{2{parity[15]}}, parity};
        w_s2  = {{2{sys[15]}}, sys} + {{2{apriori[15]}}, apriori} - {{2{parity[15]}}, parity};
        w_h1  = w_s1 >>> 1;
        w_h2  = w_s2 >>> 1;
        w_g1  = sat16({w_h1[17], w_h1});
        w_g2  = sat16({w_h2[17], w_h2});
        w_g1x = {{3{w_g1[15]}}, w_g1};
        w_g2x = {{3{w_g2[15]}}, w_g2};
    end

    // Trellis butterflies, then normalize against the new state-0 metric.
    always_comb begin
        w_n[0]  = amax(r_a[0] + w_g1x, r_a[1] - w_g1x);
        w_n[4]  = amax(r_a[0] - w_g1x, r_a[1] + w_g1x);
        w_n[1]  = amax(r_a[2] - w_g2x, r_a[3] + w_g2x);
        w_n[5]  = amax(r_a[2] + w_g2x, r_a[3] - w_g2x);
        w_n[2]  = amax(r_a[4] + w_g2x, r_a[5] - w_g2x);
        w_n[6]  = amax(r_a[4] - w_g2x, r_a[5] + w_g2x);
        w_n[3]  = amax(r_a[6] - w_g1x, r_a[7] + w_g1x);
        w_n[7]  = amax(r_a[6] + w_g1x, r_a[7] - w_g1x);
        w_nn[0] = '0;
        w_nn[1] = w_n[1] - w_n[0];
        w_nn[2] = w_n[2] - w_n[0];
        w_nn[3] = w_n[3] - w_n[0];
        w_nn[4] = w_n[4] - w_n[0];
        w_nn[5] = w_n[5] - w_n[0];
        w_nn[6] = w_n[6] - w_n[0];
        w_nn[7] = w_n[7] - w_n[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_blklen <= '0;
            r_cnt    <= '0;
            r_vbo    <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_g1     <= '0;
            r_g2     <= '0;
            r_a      <= A_INIT;
            r_aout   <= '{default: '0};
        end else begin
            r_vbo   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_blklen) begin
                        if (blklen >= 16'd40 && blklen <= 16'd6144) begin
                            r_blklen <= blklen;
                            r_vbo    <= 1'b1;
                            r_cnt    <= '0;
                            r_a      <= A_INIT;
                            r_state  <= RUN;
                        end else begin
                            r_err    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        // Outputs carry the metrics before this step; registers advance.
                        r_valid   <= 1'b1;
                        r_g1      <= w_g1;
                        r_g2      <= w_g2;
                        r_aout[0] <= sat16(r_a[0]);
                        r_aout[1] <= sat16(r_a[1]);
                        r_aout[2] <= sat16(r_a[2]);
                        r_aout[3] <= sat16(r_a[3]);
                        r_aout[4] <= sat16(r_a[4]);
                        r_aout[5] <= sat16(r_a[5]);
                        r_aout[6] <= sat16(r_a[6]);
                        r_aout[7] <= sat16(r_a[7]);
                        r_a       <= w_nn;
                        r_cnt     <= r_cnt + 16'd1;
                        if (r_cnt == r_blklen + 16'd3) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid_blklen_out = r_vbo;
    assign blklen_out       = r_blklen;
    assign valid_branch     = r_valid;
    assign valid_alpha      = r_valid;
    assign init_branch1     = r_g1;
    assign init_branch2     = r_g2;
    assign alpha_0          = r_aout[0];
    assign alpha_1          = r_aout[1];
    assign alpha_2          = r_aout[2];
    assign alpha_3          = r_aout[3];
    assign alpha_4          = r_aout[4];
    assign alpha_5          = r_aout[5];
    assign alpha_6          = r_aout[6];
    assign alpha_7          = r_aout[7];
    assign done             = r_done;
    assign err              = r_err;
    assign fsm_state        = r_state;

endmodule

// File: tb/tb_alpha_fwd.sv
module tb_alpha_fwd;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               valid_blklen = 1'b0;
    logic [15:0]        blklen = '0;
    logic               valid_in = 1'b0;
    logic signed [15:0] sys = '0, parity = '0, apriori = '0;
    logic               valid_blklen_out, valid_branch, valid_alpha, done, err;
    logic [15:0]        blklen_out;
    logic signed [15:0] init_branch1, init_branch2;
    logic signed [15:0] alpha_0, alpha_1, alpha_2, alpha_3, alpha_4, alpha_5, alpha_6, alpha_7;
    logic [1:0]         fsm_state;

    alpha_fwd dut (
        .clk(clk), .rst(rst), .valid_blklen(valid_blklen), .blklen(blklen),
        .valid_in(valid_in), .sys(sys), .parity(parity), .apriori(apriori),
        .valid_blklen_out(valid_blklen_out), .blklen_out(blklen_out),
        .valid_branch(valid_branch), .valid_alpha(valid_alpha),
        .init_branch1(init_branch1), .init_branch2(init_branch2),
        .alpha_0(alpha_0), .alpha_1(alpha_1), .alpha_2(alpha_2), .alpha_3(alpha_3),
        .alpha_4(alpha_4), .alpha_5(alpha_5), .alpha_6(alpha_6), .alpha_7(alpha_7),
        .done(done), .err(err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]       g1;
        logic [15:0]       g2;
        logic [7:0][15:0]  a;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;

    // Reference model state
    int   m_a[8];
    bit   m_run = 0;
    int   m_cnt = 0;
    int   m_blk = 0;

    function automatic int wrap19(input int v);
        int r;
        r = v & 32'h7FFFF;
        if (r >= 32'h40000) r = r - 32'h80000;
        return r;
    endfunction

    function automatic int clamp16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int mx(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    task automatic model_init();
        m_a[0] = 0;
        for (int i = 1; i < 8; i++) m_a[i] = -128;
    endtask

    task automatic model_step(input int s, input int a, input int p);
        int   g1, g2, n[8];
        exp_t e;
        g1 = clamp16((s + a + p) >>> 1);
        g2 = clamp16((s + a - p) >>> 1);
        e.g1 = g1[15:0];
        e.g2 = g2[15:0];
        for (int i = 0; i < 8; i++) begin
            int c;
            c = clamp16(m_a[i]);
            e.a[i] = c[15:0];
        end
        q.push_back(e);
        n[0] = mx(wrap19(m_a[0] + g1), wrap19(m_a[1] - g1));
        n[4] = mx(wrap19(m_a[0] - g1), wrap19(m_a[1] + g1));
        n[1] = mx(wrap19(m_a[2] - g2), wrap19(m_a[3] + g2));
        n[5] = mx(wrap19(m_a[2] + g2), wrap19(m_a[3] - g2));
        n[2] = mx(wrap19(m_a[4] + g2), wrap19(m_a[5] - g2));
        n[6] = mx(wrap19(m_a[4] - g2), wrap19(m_a[5] + g2));
        n[3] = mx(wrap19(m_a[6] - g1), wrap19(m_a[7] + g1));
        n[7] = mx(wrap19(m_a[6] + g1), wrap19(m_a[7] - g1));
        for (int i = 0; i < 8; i++) m_a[i] = wrap19(n[i] - n[0]);
    endtask

    // Scoreboard: compares every DUT step against the queued expectation.
    always @(negedge clk) begin
        if (rst && valid_branch) begin
            exp_t e;
            n_out++;
            n_tests++;
            if (valid_alpha !== 1'b1) begin
                n_fail++;
                $display("FAIL valid_alpha: got %b want 1", valid_alpha);
            end
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra_step: got output step %0d want none", n_out);
            end else begin
                e = q.pop_front();
                n_tests++;
                if ({init_branch1, init_branch2, alpha_7, alpha_6, alpha_5, alpha_4,
                     alpha_3, alpha_2, alpha_1, alpha_0} !== e) begin
                    n_fail++;
                    $display("FAIL sb_step: got %h want %h", {init_branch1, init_branch2,
                             alpha_7, alpha_6, alpha_5, alpha_4, alpha_3, alpha_2, alpha_1,
                             alpha_0}, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_block(input int len);
        bit ok;
        ok = (len >= 40 && len <= 6144);
        valid_blklen = 1'b1;
        blklen = len[15:0];
        @(posedge clk); #1;
        valid_blklen = 1'b0;
        n_tests++;
        if (ok) begin
            m_run = 1; m_cnt = 0; m_blk = len; n_out = 0;
            model_init();
            if ({valid_blklen_out, blklen_out, fsm_state, err} !== {1'b1, len[15:0], 2'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL accept_len: got vbo=%b len=%0d st=%0d err=%b want 1 %0d 1 0",
                         valid_blklen_out, blklen_out, fsm_state, err, len);
            end
        end else if ({err, valid_blklen_out, fsm_state} !== {1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reject_len: got err=%b vbo=%b st=%0d want 1 0 0",
                     err, valid_blklen_out, fsm_state);
        end
    endtask

    task automatic send_sym(input int s, input int a, input int p);
        sys = s[15:0]; apriori = a[15:0]; parity = p[15:0];
        valid_in = 1'b1;
        if (m_run && m_cnt < m_blk + 4) begin
            model_step(s, a, p);
            m_cnt++;
            if (m_cnt == m_blk + 4) m_run = 0;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic check_block_end(input string name, input int len);
        idle(2);
        n_tests++;
        if (n_out !== len + 4 || q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_count: got %0d steps (%0d pending) want %0d", name, n_out, q.size(), len + 4);
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({valid_blklen_out, blklen_out, valid_branch, valid_alpha, init_branch1, init_branch2,
             alpha_0, alpha_1, alpha_2, alpha_3, alpha_4, alpha_5, alpha_6, alpha_7,
             done, err, fsm_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero st=%0d vb=%b want all 0", fsm_state, valid_branch);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_zero_block();
        start_block(40);
        send_sym(0, 0, 0);
        n_tests++;
        if ({alpha_0, alpha_1, alpha_7, init_branch1, init_branch2} !== {16'sd0, -16'sd128, -16'sd128, 16'sd0, 16'sd0}) begin
            n_fail++;
            $display("FAIL zero_step0: got a0=%0d a1=%0d a7=%0d g1=%0d want 0 -128 -128 0",
                     alpha_0, alpha_1, alpha_7, init_branch1);
        end
        send_sym(0, 0, 0);
        n_tests++;
        if ({alpha_0, alpha_3, alpha_4, alpha_5} !== {16'sd0, -16'sd128, 16'sd0, -16'sd128}) begin
            n_fail++;
            $display("FAIL zero_step1: got a0=%0d a3=%0d a4=%0d a5=%0d want 0 -128 0 -128",
                     alpha_0, alpha_3, alpha_4, alpha_5);
        end
        for (int i = 2; i < 44; i++) send_sym(0, 0, 0);
        n_tests++;
        if ({done, fsm_state, valid_branch} !== {1'b1, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b st=%0d want 1 2", done, fsm_state);
        end
        idle(1);
        n_tests++;
        if ({done, fsm_state} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL done_width: got done=%b st=%0d want 0 0", done, fsm_state);
        end
        check_block_end("zero", 40);
    endtask

    task automatic test_first_symbol();
        start_block(40);
        send_sym(10, 0, 4);
        n_tests++;
        if ({init_branch1, init_branch2} !== {16'sd7, 16'sd3}) begin
            n_fail++;
            $display("FAIL branch_10_4: got g1=%0d g2=%0d want 7 3", init_branch1, init_branch2);
        end
        send_sym(0, 0, 0);
        n_tests++;
        if ({alpha_0, alpha_1, alpha_2, alpha_3, alpha_4, alpha_5, alpha_6, alpha_7} !==
            {16'sd0, -16'sd132, -16'sd132, -16'sd128, -16'sd14, -16'sd132, -16'sd132, -16'sd128}) begin
            n_fail++;
            $display("FAIL alpha_step1: got %0d %0d %0d %0d %0d %0d %0d %0d want 0 -132 -132 -128 -14 -132 -132 -128",
                     alpha_0, alpha_1, alpha_2, alpha_3, alpha_4, alpha_5, alpha_6, alpha_7);
        end
        for (int i = 2; i < 44; i++) send_sym(i, -i, 3 * i);
        check_block_end("first", 40);
    endtask

    task automatic test_saturation();
        start_block(40);
        send_sym(32767, 32767, 32767);
        n_tests++;
        if ({init_branch1, init_branch2} !== {16'sd32767, 16'sd16383}) begin
            n_fail++;
            $display("FAIL sat_pos: got g1=%0d g2=%0d want 32767 16383", init_branch1, init_branch2);
        end
        send_sym(-32768, -32768, -32768);
        n_tests++;
        if (init_branch1 !== -16'sd32768) begin
            n_fail++;
            $display("FAIL sat_neg: got g1=%0d want -32768", init_branch1);
        end
        for (int i = 2; i < 44; i++) send_sym(32767 - i, -32768 + i, (i % 2) ? 32767 : -32768);
        check_block_end("sat", 40);
    endtask

    task automatic test_lengths();
        start_block(39);
        idle(1);
        n_tests++;
        if ({err, valid_blklen_out, fsm_state} !== {1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL err_width: got err=%b vbo=%b st=%0d want 0 0 0", err, valid_blklen_out, fsm_state);
        end
        start_block(6145);
        idle(1);
        start_block(6144);
        for (int i = 0; i < 6148; i++)
            send_sym($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                     $urandom_range(0, 2000) - 1000);
        check_block_end("len6144", 6144);
    endtask

    task automatic test_reset_midblock();
        start_block(40);
        for (int i = 0; i < 10; i++) send_sym(100 + i, 50, -20 * i);
        rst = 1'b0;
        #2;
        n_tests++;
        if ({valid_blklen_out, blklen_out, valid_branch, init_branch1, init_branch2,
             alpha_0, alpha_1, alpha_2, alpha_3, alpha_4, alpha_5, alpha_6, alpha_7,
             done, err, fsm_state} !== '0) begin
            n_fail++;
            $display("FAIL midblock_reset: got st=%0d g1=%0d a1=%0d want all 0", fsm_state, init_branch1, alpha_1);
        end
        q.delete();
        m_run = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        start_block(40);
        for (int i = 0; i < 44; i++) send_sym(0, 0, 0);
        check_block_end("restart", 40);
    endtask

    task automatic test_back_to_back_gaps();
        start_block(60);
        while (m_run) begin
            idle($urandom_range(0, 2));
            send_sym($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                     $urandom_range(0, 65535) - 32768);
        end
        for (int i = 0; i < 4; i++) send_sym(500, 500, 500);
        check_block_end("gaps", 60);
    endtask

    initial begin
        test_reset();
        test_zero_block();
        test_first_symbol();
        test_saturation();
        test_lengths();
        test_reset_midblock();
        test_back_to_back_gaps();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
